icache_refill_ctrl: RTL

ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

---
 rtl/icache_refill_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/icache_refill_ctrl.sv
// Two-way instruction cache refill controller: accepts a miss, bursts one line in
// from memory beat by beat, picks a victim way from valid/LRU state and writes it.
module icache_refill_ctrl #(
  parameter int INDEXW = 6,
  parameter int TAGW   = 21,
  parameter int BEATS  = 8
) (
  input  logic                  Clk,
  input  logic                  Rest,
  input  logic                  MissReq,
  input  logic [31:0]           MissAddr,
  output logic                  MissAck,
  input  logic                  CacheStateFluah,
  input  logic                  HitValid,
  input  logic [INDEXW-1:0]     HitIndex,
  input  logic                  HitWay,
  input  logic [INDEXW-1:0]     LookupIndex,
  output logic [1:0]            LookupValid,
  output logic                  MemReq,
  output logic [31:0]           MemAddr,
  input  logic                  MemGrant,
  input  logic                  MemBeat,
  input  logic [31:0]           MemData,
  output logic [1:0]            WayWe,
  output logic [INDEXW-1:0]     WrIndex,
  output logic [TAGW-1:0]       WrTag,
  output logic [32*BEATS-1:0]   WrLine,
  output logic                  RefillDone,
  output logic                  Busy
);

  localparam int SETS = 1 << INDEXW;
  localparam int CW   = $clog2(BEATS + 1);

  typedef enum logic [2:0] {IDLE, REQ, RECV, WRITE, DONE, DRAIN} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [31:0]       addr;
  logic [CW-1:0]     cnt;
  logic [SETS-1:0]   valid0;
  logic [SETS-1:0]   valid1;
  logic [SETS-1:0]   lru;
  logic [INDEXW-1:0] idx;
  logic              victim;
  logic              last_beat;
  logic              wr_cycle;

  assign idx       = addr[5 +: INDEXW];
  assign last_beat = MemBeat && (cnt == CW'(BEATS - 1));
  assign wr_cycle  = (state == WRITE);

  // Fill invalid ways first (way0 before way1); otherwise LRU names the way to evict.
  always_comb begin
    victim = 1'b0;
    if (!valid0[idx])      victim = 1'b0;
    else if (!valid1[idx]) victim = 1'b1;
    else                   victim = lru[idx];
  end

  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (MissReq && !CacheStateFluah) state_nxt = REQ;
      REQ:     if (CacheStateFluah)             state_nxt = IDLE;
               else if (MemGrant)               state_nxt = RECV;
      RECV:    if (CacheStateFluah)             state_nxt = DRAIN;
               else if (last_beat)              state_nxt = WRITE;
      WRITE:                                    state_nxt = DONE;
      DONE:                                     state_nxt = IDLE;
      DRAIN:   if (cnt == CW'(BEATS))           state_nxt = IDLE;
      default:                                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    MissAck    = (state == IDLE) && MissReq && !CacheStateFluah && !Rest;
    MemReq     = (state == REQ);
    WayWe      = wr_cycle ? (victim ? 2'b10 : 2'b01) : 2'b00;
    RefillDone = (state == DONE);
    Busy       = (state != IDLE);
  end

  assign MemAddr     = {addr[31:5], 5'b0};
  assign WrIndex     = idx;
  assign WrTag       = addr[31 -: TAGW];
  assign LookupValid = {valid1[LookupIndex], valid0[LookupIndex]};

  // Beat counter keeps running in DRAIN so an abandoned burst is fully absorbed.
  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      addr   <= '0;
      cnt    <= '0;
      WrLine <= '0;
    end else begin
      if (MissAck) addr <= MissAddr;
      if (state == REQ && MemGrant)
        cnt <= '0;
      else if ((state == RECV || (state == DRAIN && cnt != CW'(BEATS))) && MemBeat)
        cnt <= cnt + CW'(1);
      if (state == RECV && MemBeat) begin
        for (int k = 0; k < BEATS; k++)
          if (cnt == CW'(k)) WrLine[k*32 +: 32] <= MemData;
      end
    end
  end

  // Flush beats a coincident line write; a refill write beats a hit update on its set.
  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      valid0 <= '0;
      valid1 <= '0;
      lru    <= '0;
    end else begin
      if (CacheStateFluah) begin
        valid0 <= '0;
        valid1 <= '0;
      end else if (wr_cycle) begin
        if (victim) valid1[idx] <= 1'b1;
        else        valid0[idx] <= 1'b1;
      end
      if (HitValid && !(wr_cycle && HitIndex == idx)) lru[HitIndex] <= ~HitWay;
      if (wr_cycle) lru[idx] <= ~victim;
    end
  end

endmodule
